// File: rtl/chdr_32f_to_16s_if.sv
// chdr_32f_to_16s_if: one AXI-Stream CHDR link (64-bit data, valid, last, ready).
// Ports (modports):
//   master : drives tdata/tvalid/tlast, receives tready
//   slave  : receives tdata/tvalid/tlast, drives tready
interface chdr_32f_to_16s_if;
  localparam int unsigned DATA_W = 64;

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/chdr_32f_to_16s.sv
// chdr_32f_to_16s: converts CHDR packets carrying fc32 complex payload (I in [63:32],
// Q in [31:0]) into CHDR packets carrying Q15 sc16 payload. Two input payload lines
// are packed into one output line, the CHDR size field is rewritten and the destination
// SID may be replaced. Conversion rounds to nearest (ties away from zero) and saturates.
// Optional feature macro: SAT_COUNT_EN (saturated-lane counter on sat_count).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i          : CHDR fc32 input stream (slave modport)
//   o          : CHDR sc16 output stream (master modport)
//   set_stb/set_addr/set_data : settings bus; BASE = SID register, BASE+1 = counter clear
//   sat_count  : saturated-lane count (0 when SAT_COUNT_EN is undefined)
module chdr_32f_to_16s #(
  parameter int unsigned BASE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  chdr_32f_to_16s_if.slave         i,
  chdr_32f_to_16s_if.master        o,
  input  logic                     set_stb,
  input  logic [7:0]               set_addr,
  input  logic [31:0]              set_data,
  output logic [31:0]              sat_count
);
  localparam int unsigned SAMP_W = 16;
  localparam int unsigned HOLD_W = 2 * SAMP_W;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {HEADER, TIME, LO, HI} state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q;
  logic                sid_en_q;
  logic [SAMP_W-1:0]   sid_dst_q;
  logic                hold_we;
  logic                pay_beat;

  logic [SAMP_W-1:0]   conv_i, conv_q;
  logic                sat_i, sat_q;
  logic [15:0]         hdr_len, in_size, in_pay, new_size;
  logic [63:0]         hdr_out;

  // fc32 -> Q15 with round-half-away and saturation; returns {saturated, value}
  function automatic logic [SAMP_W:0] f32_to_q15(input logic [31:0] f);
    logic        sgn;
    logic [7:0]  e;
    logic [22:0] m;
    logic [4:0]  sh;
    logic [24:0] sum;
    logic [16:0] mag;
    sgn = f[31];
    e   = f[30:23];
    m   = f[22:0];
    sh  = '0;
    sum = '0;
    mag = '0;
    f32_to_q15 = '0;
    if (e == 8'hFF) begin
      // inf clamps and counts; NaN yields 0 silently
      if (m == 23'd0) f32_to_q15 = {1'b1, sgn ? 16'h8000 : 16'h7FFF};
    end else if (e >= 8'd128) begin
      // |x| >= 2 always exceeds the Q15 range after rounding
      f32_to_q15 = {1'b1, sgn ? 16'h8000 : 16'h7FFF};
    end else if (e >= 8'd111) begin
      // |x*2^15| = {1,m} >> (135-e); shift range 8..24, below that the result is 0
      sh  = 5'(8'd135 - e);
      sum = {1'b0, 1'b1, m} + (25'd1 << (sh - 5'd1));
      mag = 17'(sum >> sh);
      if (!sgn) begin
        f32_to_q15 = (mag > 17'd32767) ? {1'b1, 16'h7FFF} : {1'b0, mag[15:0]};
      end else begin
        f32_to_q15 = (mag > 17'd32768) ? {1'b1, 16'h8000} : {1'b0, 16'(-mag[15:0])};
      end
    end
  endfunction

  assign {sat_i, conv_i} = f32_to_q15(i.tdata[63:32]);
  assign {sat_q, conv_q} = f32_to_q15(i.tdata[31:0]);

  // Header rewrite: payload halves, header (and time) length is preserved
  always_comb begin
    hdr_len  = i.tdata[61] ? 16'd16 : 16'd8;
    in_size  = i.tdata[47:32];
    in_pay   = (in_size >= hdr_len) ? (in_size - hdr_len) : 16'd0;
    new_size = hdr_len + (in_pay >> 1);
    hdr_out  = {i.tdata[63:48], new_size,
                sid_en_q ? {i.tdata[15:0], sid_dst_q} : i.tdata[31:0]};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HEADER;
    else        state_q <= state_d;
  end

  // Next state and stream handshake
  always_comb begin
    state_d  = state_q;
    o.tvalid = 1'b0;
    o.tlast  = 1'b0;
    o.tdata  = {conv_i, conv_q, 32'h0};
    i.tready = 1'b0;
    hold_we  = 1'b0;
    pay_beat = 1'b0;
    case (state_q)
      HEADER: begin
        o.tvalid = i.tvalid;
        i.tready = o.tready;
        o.tdata  = hdr_out;
        if (i.tvalid && o.tready) state_d = i.tdata[61] ? TIME : LO;
      end
      TIME: begin
        o.tvalid = i.tvalid;
        i.tready = o.tready;
        o.tlast  = i.tvalid & i.tlast;
        o.tdata  = i.tdata;
        if (i.tvalid && o.tready) state_d = i.tlast ? HEADER : LO;
      end
      LO: begin
        if (i.tlast) begin
          // odd line count: emit the lone pair padded with zeros
          o.tvalid = i.tvalid;
          i.tready = o.tready;
          o.tlast  = i.tvalid;
          if (i.tvalid && o.tready) begin
            pay_beat = 1'b1;
            state_d  = HEADER;
          end
        end else begin
          i.tready = 1'b1;
          if (i.tvalid) begin
            hold_we  = 1'b1;
            pay_beat = 1'b1;
            state_d  = HI;
          end
        end
      end
      HI: begin
        o.tvalid = i.tvalid;
        i.tready = o.tready;
        o.tlast  = i.tvalid & i.tlast;
        o.tdata  = {hold_q, conv_i, conv_q};
        if (i.tvalid && o.tready) begin
          pay_beat = 1'b1;
          state_d  = i.tlast ? HEADER : LO;
        end
      end
      default: state_d = HEADER;
    endcase
  end

  // Hold register for the first pair of a packed output line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       hold_q <= '0;
    else if (hold_we) hold_q <= {conv_i, conv_q};
  end

  // SID register; only consulted while a header is on the bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sid_en_q  <= 1'b0;
      sid_dst_q <= '0;
    end else if (set_stb && (set_addr == 8'(BASE))) begin
      sid_en_q  <= set_data[16];
      sid_dst_q <= set_data[15:0];
    end
  end

  wire unused_set_data = &{1'b0, set_data[31:17]};

`ifdef SAT_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   cnt_sum;

  assign cnt_sum = {1'b0, cnt_q} + (CNT_W + 1)'({1'b0, sat_i} + {1'b0, sat_q});

  // Saturating count of clamped lanes over all payload beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         cnt_q <= '0;
    else if (set_stb && (set_addr == 8'(BASE + 1)))     cnt_q <= '0;
    else if (pay_beat)                                  cnt_q <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  assign sat_count = cnt_q;
`else
  assign sat_count = '0;
  wire unused_sat = &{1'b0, sat_i, sat_q, pay_beat};
`endif

endmodule

// File: tb/tb_chdr_32f_to_16s.sv
// tb_chdr_32f_to_16s: randomized and directed stimulus against a packet-level model of
// the fc32 -> sc16 CHDR converter (real-arithmetic conversion, sample-stream packing).
module tb_chdr_32f_to_16s;
  localparam int unsigned BASE = 0;

  logic        clk;
  logic        rst_n;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] sat_count;

  chdr_32f_to_16s_if in_if ();
  chdr_32f_to_16s_if out_if ();

  chdr_32f_to_16s #(.BASE(BASE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i        (in_if.slave),
    .o        (out_if.master),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .sat_count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [64:0]     exp_q[$];
  logic            sid_en_m;
  logic [15:0]     sid_dst_m;
  longint unsigned sat_m;
  int              rdy_mode;   // 0 random, 1 always ready, 2 never ready
  logic            rnd_rdy;

  assign out_if.tready = (rdy_mode == 0) ? rnd_rdy : (rdy_mode == 1);

  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference conversion in real arithmetic; returns {saturated, value}
  function automatic logic [16:0] ref_q15(input logic [31:0] f);
    int  e;
    real x, y, r;
    int  iv;
    e = int'(f[30:23]);
    if (e == 255) return (f[22:0] != 23'd0) ? 17'h0 : (f[31] ? {1'b1, 16'h8000} : {1'b1, 16'h7FFF});
    if (e == 0) return 17'h0;
    x = (8388608.0 + real'(f[22:0])) * (2.0 ** real'(e - 150));
    y = f[31] ? -x * 32768.0 : x * 32768.0;
    if (y >= 32767.5) return {1'b1, 16'h7FFF};
    if (y <= -32768.5) return {1'b1, 16'h8000};
    r  = (y >= 0.0) ? $floor(y + 0.5) : -$floor(-y + 0.5);
    iv = int'(r);
    return {1'b0, 16'(iv)};
  endfunction

  function automatic logic [31:0] rand_lane();
    logic        s;
    logic [22:0] m;
    s = 1'($urandom);
    m = 23'($urandom);
    case ($urandom_range(0, 9))
      0:       return {s, 8'hFF, m | 23'h1};
      1:       return {s, 8'hFF, 23'h0};
      2:       return {s, 8'h00, m};
      3:       return {s, 8'(127 + $urandom_range(0, 1)), m};
      default: return {s, 8'($urandom_range(105, 130)), m};
    endcase
  endfunction

  // One input line; random idle gaps before it, returns just after the accepting edge
  task automatic drive_line(input logic [63:0] d, input logic l);
    int n;
    while ($urandom_range(0, 3) == 0) begin
      in_if.tvalid = 1'b0;
      @(posedge clk); #1;
    end
    in_if.tvalid = 1'b1;
    in_if.tdata  = d;
    in_if.tlast  = l;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_if.tready) break;
      n++;
      if (n > 500) begin
        check("stall", 64'(n), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
  endtask

  // Queue the expected output of a whole packet
  task automatic expect_pkt(input logic [63:0] hdr, input logic [63:0] tim, input logic [63:0] pay[$]);
    int          hb, sz, pl, nl;
    logic [15:0] s[$];
    logic [16:0] r1, r2;
    logic [15:0] c2, c3;
    hb = hdr[61] ? 16 : 8;
    sz = int'(hdr[47:32]);
    pl = (sz >= hb) ? sz - hb : 0;
    exp_q.push_back({1'b0, hdr[63:48], 16'(hb + pl / 2),
                     sid_en_m ? {hdr[15:0], sid_dst_m} : hdr[31:0]});
    if (hdr[61]) exp_q.push_back({pay.size() == 0, tim});
    foreach (pay[k]) begin
      r1 = ref_q15(pay[k][63:32]);
      r2 = ref_q15(pay[k][31:0]);
      s.push_back(r1[15:0]);
      s.push_back(r2[15:0]);
      sat_m += longint'(r1[16]) + longint'(r2[16]);
    end
    nl = (pay.size() + 1) / 2;
    for (int k = 0; k < nl; k++) begin
      c2 = (4 * k + 2 < s.size()) ? s[4 * k + 2] : 16'h0;
      c3 = (4 * k + 3 < s.size()) ? s[4 * k + 3] : 16'h0;
      exp_q.push_back({k == nl - 1, s[4 * k], s[4 * k + 1], c2, c3});
    end
  endtask

  task automatic send_pkt(input logic [63:0] hdr, input logic [63:0] tim, input logic [63:0] pay[$]);
    expect_pkt(hdr, tim, pay);
    drive_line(hdr, 1'b0);
    if (hdr[61]) drive_line(tim, pay.size() == 0);
    foreach (pay[k]) drive_line(pay[k], k == pay.size() - 1);
  endtask

  task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    @(posedge clk); #1;
    set_stb  = 1'b0;
  endtask

  function automatic logic [31:0] exp_sat();
`ifdef SAT_COUNT_EN
    return (sat_m > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(sat_m);
`else
    return 32'h0;
`endif
  endfunction

  // Output monitor: every accepted output beat is matched against the model queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_if.tvalid && out_if.tready) begin
        if (exp_q.size() == 0) check("extra_beat", 64'(exp_q.size()), 64'd1);
        else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          check("data", out_if.tdata, e[63:0]);
          check("last", 64'(out_if.tlast), 64'(e[64]));
        end
      end else if (!out_if.tvalid) begin
        check("idle_last", 64'(out_if.tlast), 64'd0);
      end
    end
  end

  initial begin
    logic [63:0] pay[$];
    logic [63:0] hdr;
    int          np;
    logic        ht;

    rst_n = 1'b0;
    in_if.tvalid = 1'b0; in_if.tlast = 1'b0; in_if.tdata = '0;
    set_stb = 1'b0; set_addr = '0; set_data = '0;
    rdy_mode = 1; rnd_rdy = 1'b1;
    sid_en_m = 1'b0; sid_dst_m = '0; sat_m = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", 64'(out_if.tvalid), 64'd0);
    check("rst_sat", 64'(sat_count), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic packing, no time
    pay = '{64'h3F000000_BF000000, 64'h3F800000_00000000};
    send_pkt(64'h0000_0018_0000_0000, 64'h0, pay);

    // Time packet, odd payload count
    pay = '{64'h3E800000_BE800000, 64'h3DCCCCCD_C2C80000, 64'h3F000000_3F000000};
    send_pkt(64'h2000_0028_0000_0001, 64'h1122_3344_5566_7788, pay);

    // Special lanes and saturation count
    set_reg(8'(BASE + 1), 32'h0);
    sat_m = 0;
    pay = '{64'hC0000000_7FC00000, 64'h7F800000_37800000};
    send_pkt(64'h0000_0018_0000_0002, 64'h0, pay);
    @(negedge clk);
    check("sat_cnt", 64'(sat_count), 64'(exp_sat()));
    @(posedge clk); #1;

    // Time-only packet (last on the time line)
    pay = '{};
    send_pkt(64'h2000_0010_0000_0003, 64'hDEAD_BEEF_0000_0001, pay);

    // Backpressure while in HI
    pay = '{64'h3F000000_BF000000, 64'h3F800000_00000000};
    expect_pkt(64'h0000_0018_0000_0004, 64'h0, pay);
    drive_line(64'h0000_0018_0000_0004, 1'b0);
    drive_line(pay[0], 1'b0);
    rdy_mode = 2;
    in_if.tvalid = 1'b1; in_if.tdata = pay[1]; in_if.tlast = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rdy", 64'(in_if.tready), 64'd0);
      check("bp_data", out_if.tdata, exp_q[0][63:0]);
      @(posedge clk); #1;
    end
    rdy_mode = 1;
    @(negedge clk);
    check("bp_rel_rdy", 64'(in_if.tready), 64'd1);
    @(posedge clk); #1;
    in_if.tvalid = 1'b0; in_if.tlast = 1'b0;
    check("bp_drain", 64'(exp_q.size()), 64'd0);

    // SID rewrite
    set_reg(8'(BASE), 32'h0001ABCD);
    sid_en_m = 1'b1; sid_dst_m = 16'hABCD;
    pay = '{64'h3F000000_BF000000};
    send_pkt(64'h0000_0010_1234_5678, 64'h0, pay);

    // Reset mid-packet while in HI
    pay = '{64'h3F000000_BF000000, 64'h3F000000_3F000000, 64'h3F000000_3F000000};
    expect_pkt(64'h0000_0020_0000_0005, 64'h0, pay);
    drive_line(64'h0000_0020_0000_0005, 1'b0);
    drive_line(pay[0], 1'b0);
    in_if.tvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rstm_vld", 64'(out_if.tvalid), 64'd0);
    check("rstm_sat", 64'(sat_count), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    sid_en_m = 1'b0; sid_dst_m = '0; sat_m = 0;
    pay = '{64'h3F000000_BF000000, 64'hBF800000_3F7FFFFF};
    send_pkt(64'h0000_0018_0000_0006, 64'h0, pay);

    // Randomized packets with random output backpressure
    rdy_mode = 0;
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 7) == 0) begin
        set_reg(8'(BASE), $urandom);
        sid_en_m  = set_data[16];
        sid_dst_m = set_data[15:0];
      end
      ht = 1'($urandom);
      np = ht ? $urandom_range(0, 6) : $urandom_range(1, 6);
      pay = '{};
      for (int k = 0; k < np; k++) pay.push_back({rand_lane(), rand_lane()});
      hdr = {2'b00, ht, 13'($urandom), 16'((ht ? 16 : 8) + 8 * np), 32'($urandom)};
      send_pkt(hdr, {$urandom, $urandom}, pay);
    end
    rdy_mode = 1;
    @(negedge clk);
    check("final_sat", 64'(sat_count), 64'(exp_sat()));
    check("final_drain", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
